ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port data/instruction RAM between two requesters:
//  port 0 (CPU core fetch/load/store) and port 1 (program loader / debug DMA).
//  Round-robin arbitration with bounded burst lock; returns read data with the
//  RAM's fixed 1-cycle read latency, tagged to the issuing port.
//  Sits between the requesters and the RAM macro in the top-level SoC.
// PARAMETERS
//  SIZE       14  address width in words (matches RAM depth 2^SIZE)
//  DW         32  data width
//  MAX_BURST  4   max consecutive grants to one port while the other waits (>=1)
// PORTS
//  clk        in   1     system clock, single clock domain
//  rst        in   1     synchronous, active-high reset
//  req0/req1  in   1     access request, held until granted
//  we0/we1    in   1     1 = write, 0 = read
//  addr0/addr1 in  SIZE  word address
//  wdata0/wdata1 in DW   write data
//  gnt0/gnt1  out  1     combinational grant; access issued to RAM this cycle
//  rvalid0/rvalid1 out 1 registered; read data for that port valid this cycle
//  rdata0/rdata1 out DW  = ram_rdata (shared), qualified by rvalidN
//  ram_wrEn   out  1     RAM write enable
//  ram_addr   out  SIZE  RAM address
//  ram_wdata  out  DW    RAM write data
//  ram_rdata  in   DW    RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  - Reset: state=IDLE, last=1 (port 0 wins first tie), burst_cnt=0,
//    rvalid0/1=0. Outputs with no grant: gnt=0, ram_wrEn=0, ram_addr=0, ram_wdata=0.
//  - FSM states: IDLE, OWN0, OWN1. Grant logic (comb, per cycle):
//    IDLE: one req -> grant it; both -> grant port != last.
//    OWNk: reqk && (burst_cnt<MAX_BURST || !req_other) -> grant k;
//          else req_other -> grant other; else no grant.
//  - Next state = OWN<granted>, IDLE if no grant. last <= granted port.
//  - burst_cnt: same owner -> saturating +1 (cap MAX_BURST); new owner -> 1;
//    no grant -> 0.
//  - Granted port drives ram_addr/ram_wdata; ram_wrEn = we of granted port.
//  - At most one gnt per cycle; gnt0&gnt1 never both 1.
//  - Read latency: granted read in cycle T -> rvalidN=1 in T+1, rdata=ram_rdata.
//    Writes never raise rvalid. Back-to-back reads give rvalid every cycle.
//  - Owner switch mid-stream: in-flight rvalid still goes to issuing port.
//  - Reset mid-operation: pending rvalid dropped (0 next cycle), grant lost;
//    requesters must re-issue.
//  - MAX_BURST=1 degenerates to strict alternation under contention.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1, stat_wait0,
//    stat_wait1 (32 bits each): granted cycles and req-but-not-granted cycles
//    per port; wrap at 2^32; cleared by rst.
//  Not defined: no counters, no stat ports; arbitration identical.
// STRUCTURE
//  Package ram_arb_pkg: state encoding (IDLE/OWN0/OWN1), port index
//  constants, default SIZE/DW.
//  Sub-module arb_stat_ctr (one 32-bit wrapping counter with enable),
//  instantiated 4x only under ARB_STATS_EN. Grant logic stays in top.
// TESTING
//  1 Only req0 read addr 0x0005, RAM[5]=0xDEADBEEF -> gnt0 same cycle,
//    rvalid0=1 and rdata0=0xDEADBEEF next cycle; rvalid1=0.
//  2 req0 and req1 both high from first cycle after reset -> gnt0 first;
//    under continuous contention: 4 gnt0, then 4 gnt1, alternating.
//  3 req1 write addr 0x0010 data 0x12345678, req0 idle -> ram_wrEn=1,
//    ram_addr=0x0010; no rvalid1; later port-0 read of 0x0010 returns 0x12345678.
//  4 req0 continuous for 10 cycles, req1 idle -> 10 consecutive gnt0
//    (no forced switch); req1 rises at cycle 10 -> gnt1 next cycle.
//  5 Port-0 read granted in T, ownership switches to port 1 in T+1 ->
//    rvalid0=1 (not rvalid1) in T+1.
//  6 rst asserted the cycle after a granted read -> rvalid0=0 next cycle,
//    state IDLE; with ARB_STATS_EN all stat_* read 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding,
// port index constants and default geometry.
package ram_arb_pkg;

  // Default geometry and burst bound
  localparam int DEF_SIZE      = 14;
  localparam int DEF_DW        = 32;
  localparam int DEF_MAX_BURST = 4;

  // Port indices, also used as the encoding of the "last granted" flag
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Arbiter ownership state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Ownership state that corresponds to a granted port
  function automatic arb_state_e owner_state(input logic port);
    arb_state_e st;
    if (port == PORT1) begin
      st = ST_OWN1;
    end else begin
      st = ST_OWN0;
    end
    return st;
  endfunction

endpackage

// File: rtl/arb_stat_ctr.sv
// One 32-bit event counter with enable; wraps at 2^32, cleared by rst.
// Instantiated by ram_port_arbiter only when ARB_STATS_EN is defined.
module arb_stat_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  // Count enabled cycles; natural wrap on overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 32'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port RAM with 1-cycle read latency.
// Port 0 = CPU core, port 1 = loader / debug DMA. Round-robin with a bounded
// burst lock: an owner keeps the RAM while it requests, but hands over after
// MAX_BURST consecutive grants if the other port is waiting.
// Optional build macro: ARB_STATS_EN adds per-port grant/wait counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int DW        = DEF_DW,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            we0,
  input  logic [SIZE-1:0] addr0,
  input  logic [DW-1:0]   wdata0,
  input  logic            req1,
  input  logic            we1,
  input  logic [SIZE-1:0] addr1,
  input  logic [DW-1:0]   wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [DW-1:0]   rdata0,
  output logic [DW-1:0]   rdata1,
  output logic            ram_wrEn,
  output logic [SIZE-1:0] ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]     stat_gnt0,
  output logic [31:0]     stat_gnt1,
  output logic [31:0]     stat_wait0,
  output logic [31:0]     stat_wait1
`endif
);

  // Burst counter must hold values 0..MAX_BURST
  localparam int BCW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BURST_MAX = BCW'(MAX_BURST);
  localparam logic [BCW-1:0] BURST_ONE = BCW'(1);

  arb_state_e     state_q, state_d;
  logic           last_q, last_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic           rvalid0_q, rvalid0_d;
  logic           rvalid1_q, rvalid1_d;

  logic           gnt0_s, gnt1_s;
  logic           burst_open_s;

  // Owner may keep the RAM only while its burst budget is not exhausted
  assign burst_open_s = (burst_cnt_q < BURST_MAX);

  // Grant decision: at most one port per cycle; nothing is granted in reset
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 && req1) begin
            if (last_q == PORT1) begin
              gnt0_s = 1'b1;
            end else begin
              gnt1_s = 1'b1;
            end
          end else if (req0) begin
            gnt0_s = 1'b1;
          end else if (req1) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
          end
        end
        ST_OWN0: begin
          if (req0 && (burst_open_s || !req1)) begin
            gnt0_s = 1'b1;
          end else if (req1) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
          end
        end
        ST_OWN1: begin
          if (req1 && (burst_open_s || !req0)) begin
            gnt1_s = 1'b1;
          end else if (req0) begin
            gnt0_s = 1'b1;
          end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: withhold grants, next state recovers to IDLE
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // Next ownership, round-robin pointer and burst length from the grant
  always_comb begin
    state_d     = ST_IDLE;
    last_d      = last_q;
    burst_cnt_d = '0;
    if (gnt0_s) begin
      state_d = owner_state(PORT0);
      last_d  = PORT0;
      if (state_q == ST_OWN0) begin
        if (burst_open_s) begin
          burst_cnt_d = burst_cnt_q + BCW'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end else begin
        burst_cnt_d = BURST_ONE;
      end
    end else if (gnt1_s) begin
      state_d = owner_state(PORT1);
      last_d  = PORT1;
      if (state_q == ST_OWN1) begin
        if (burst_open_s) begin
          burst_cnt_d = burst_cnt_q + BCW'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end else begin
        burst_cnt_d = BURST_ONE;
      end
    end else begin
      state_d     = ST_IDLE;
      last_d      = last_q;
      burst_cnt_d = '0;
    end
  end

  // Read-return tag: a granted read answers on the issuing port next cycle
  always_comb begin
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    if (gnt0_s) begin
      rvalid0_d = ~we0;
    end else if (gnt1_s) begin
      rvalid1_d = ~we1;
    end else begin
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;
    end
  end

  // Arbiter state and read-valid registers; reset drops any pending return
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT1;
      burst_cnt_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
    end
  end

  // RAM command mux: granted port drives the macro, idle bus is all zero
  always_comb begin
    ram_wrEn  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0_s) begin
      ram_wrEn  = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1_s) begin
      ram_wrEn  = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end else begin
      ram_wrEn  = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  // Read data bus is shared; rvalidN says whose it is
  assign rdata0  = ram_rdata;
  assign rdata1  = ram_rdata;

`ifdef ARB_STATS_EN
  logic wait0_s, wait1_s;

  assign wait0_s = req0 & ~gnt0_s;
  assign wait1_s = req1 & ~gnt1_s;

  arb_stat_ctr u_stat_gnt0 (.clk(clk), .rst(rst), .en_i(gnt0_s),  .cnt_o(stat_gnt0));
  arb_stat_ctr u_stat_gnt1 (.clk(clk), .rst(rst), .en_i(gnt1_s),  .cnt_o(stat_gnt1));
  arb_stat_ctr u_stat_wt0  (.clk(clk), .rst(rst), .en_i(wait0_s), .cnt_o(stat_wait0));
  arb_stat_ctr u_stat_wt1  (.clk(clk), .rst(rst), .en_i(wait1_s), .cnt_o(stat_wait1));
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: directed stimulus pushes expected
// read returns into a queue; a monitor pops them whenever rvalid is seen.
module tb_ram_port_arbiter;

  localparam int SIZE = 14;
  localparam int DW   = 32;

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, we0, req1, we1;
  logic [SIZE-1:0] addr0, addr1;
  logic [DW-1:0]   wdata0, wdata1;
  logic            gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0]   rdata0, rdata1;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;
`ifdef ARB_STATS_EN
  logic [31:0]     stat_gnt0, stat_gnt1, stat_wait0, stat_wait1;
`endif

  logic [DW-1:0]   mem [0:(1<<SIZE)-1];
  exp_t            sb_q[$];
  exp_t            mon_e;
  int              n_vec = 0;
  int              n_err = 0;
  int              cyc_cnt = 0;
  bit              mon_en = 1'b0;
  logic            act_port;
  logic [31:0]     act_data;
  int              k0, k1;
  logic            g0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt = cyc_cnt + 1;

  // Behavioural RAM macro: registered read, 1-cycle latency
  always @(posedge clk) begin
    if (ram_wrEn === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  ram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
    ,
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_wait0(stat_wait0), .stat_wait1(stat_wait1)
`endif
  );

  function automatic logic [31:0] init_val(input logic [13:0] a);
    return {16'hA5A5, 2'b00, a};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One arbitration cycle: drive requests, check grant/RAM bus, log reads
  task automatic step(input logic r0, input logic w0, input logic [13:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [13:0] a1, input logic [31:0] d1,
                      input logic eg0, input logic eg1, input logic [31:0] ed, input string nm);
    exp_t e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    check({nm, " gnt0"}, 32'(gnt0), 32'(eg0));
    check({nm, " gnt1"}, 32'(gnt1), 32'(eg1));
    if (eg0) begin
      check({nm, " addr0"}, 32'(ram_addr), 32'(a0));
      check({nm, " wrEn0"}, 32'(ram_wrEn), 32'(w0));
      if (w0) check({nm, " wdata0"}, ram_wdata, d0);
      else begin
        e.due = cyc_cnt + 1; e.port = 1'b0; e.data = ed;
        sb_q.push_back(e);
      end
    end else if (eg1) begin
      check({nm, " addr1"}, 32'(ram_addr), 32'(a1));
      check({nm, " wrEn1"}, 32'(ram_wrEn), 32'(w1));
      if (w1) check({nm, " wdata1"}, ram_wdata, d1);
      else begin
        e.due = cyc_cnt + 1; e.port = 1'b1; e.data = ed;
        sb_q.push_back(e);
      end
    end else begin
      check({nm, " idle wrEn"}, 32'(ram_wrEn), 32'd0);
      check({nm, " idle addr"}, 32'(ram_addr), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    step(1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 32'h0, nm);
  endtask

  // Monitor: every rvalid must match the oldest expected read return
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rvalid_unexpected: rvalid0=%b rvalid1=%b at cycle %0d, expected none",
                   rvalid0, rvalid1, cyc_cnt);
        end else begin
          mon_e = sb_q.pop_front();
          n_vec++;
          act_port = rvalid1;
          act_data = (rvalid1 === 1'b1) ? rdata1 : rdata0;
          if (rvalid0 === rvalid1 || act_port !== mon_e.port ||
              act_data !== mon_e.data || cyc_cnt != mon_e.due) begin
            n_err++;
            $display("FAIL rdata: got port %0d data %h cycle %0d (rv0=%b rv1=%b), expected port %0d data %h cycle %0d",
                     act_port, act_data, cyc_cnt, rvalid0, rvalid1, mon_e.port, mon_e.data, mon_e.due);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
        mon_e = sb_q.pop_front();
        n_vec++; n_err++;
        $display("FAIL rvalid_missing: got no rvalid at cycle %0d, expected port %0d data %h",
                 cyc_cnt, mon_e.port, mon_e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << SIZE); i++) mem[i] = init_val(14'(i));
    mem[5] = 32'hDEADBEEF;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset rvalid0", 32'(rvalid0), 32'd0);
    check("reset rvalid1", 32'(rvalid1), 32'd0);
    check("reset ram_wdata", ram_wdata, 32'd0);
`ifdef ARB_STATS_EN
    check("reset stat_gnt0", stat_gnt0, 32'd0);
    check("reset stat_wait1", stat_wait1, 32'd0);
`endif
    @(posedge clk); #1;

    // Continuous contention: port 0 first, then 4/4 alternation
    k0 = 0; k1 = 0;
    for (int i = 0; i < 12; i++) begin
      g0 = (((i / 4) % 2) == 0);
      step(1'b1, 1'b0, 14'(32'h20 + k0), 32'h0, 1'b1, 1'b0, 14'(32'h30 + k1), 32'h0,
           g0, !g0, g0 ? init_val(14'(32'h20 + k0)) : init_val(14'(32'h30 + k1)), "contend");
      if (g0) k0++; else k1++;
    end
    idle("idle_a");

    // Single port-0 read
    step(1'b1, 1'b0, 14'h0005, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, "rd5");
    idle("idle_b");

    // Port-1 write, then port-0 readback
    step(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b1, 14'h0010, 32'h12345678, 1'b0, 1'b1, 32'h0, "wr10");
    step(1'b1, 1'b0, 14'h0010, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'h12345678, "rb10");
    idle("idle_c");

    // Long solo stream keeps the RAM; waiting port 1 then takes over
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 14'(32'h40 + i), 32'h0, 1'b0, 1'b0, 14'h0, 32'h0,
           1'b1, 1'b0, init_val(14'(32'h40 + i)), "solo0");
    step(1'b1, 1'b0, 14'h004A, 32'h0, 1'b1, 1'b0, 14'h0050, 32'h0, 1'b0, 1'b1, init_val(14'h0050), "takeover1");
    step(1'b1, 1'b0, 14'h004A, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, init_val(14'h004A), "back0");
    idle("idle_d");

    // Owner switch right after a port-0 read: return stays with port 0
    step(1'b1, 1'b0, 14'h0060, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, init_val(14'h0060), "sw_rd0");
    step(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h0061, 32'h0, 1'b0, 1'b1, init_val(14'h0061), "sw_rd1");
    idle("idle_e");

    // Reset the cycle after a granted read; a read issued under reset is lost
    step(1'b1, 1'b0, 14'h0005, 32'h0, 1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, "pre_rst");
    rst = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0007;
    @(posedge clk); #1;
    rst = 1'b0; req0 = 1'b0; addr0 = '0;
    @(negedge clk);
    check("post_rst rvalid0", 32'(rvalid0), 32'd0);
    check("post_rst rvalid1", 32'(rvalid1), 32'd0);
    check("post_rst gnt0", 32'(gnt0), 32'd0);
`ifdef ARB_STATS_EN
    check("post_rst stat_gnt0", stat_gnt0, 32'd0);
    check("post_rst stat_gnt1", stat_gnt1, 32'd0);
    check("post_rst stat_wait0", stat_wait0, 32'd0);
    check("post_rst stat_wait1", stat_wait1, 32'd0);
`endif
    @(posedge clk); #1;

    // Round-robin pointer restored by reset: port 0 wins the tie again
    step(1'b1, 1'b0, 14'h0070, 32'h0, 1'b1, 1'b0, 14'h0071, 32'h0, 1'b1, 1'b0, init_val(14'h0070), "rst_tie");
    step(1'b0, 1'b0, 14'h0, 32'h0, 1'b1, 1'b0, 14'h0071, 32'h0, 1'b0, 1'b1, init_val(14'h0071), "rst_tie1");
    idle("idle_f");
    idle("idle_g");

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
